// File: rtl/systolic_pkg.sv
// Shared definitions for the systolic array feeder: controller state
// encoding, default base addresses of the weight and im2col matrices,
// and small elaboration-time helpers for sizing counters.
package systolic_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    STREAM = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam logic [31:0] DEFAULT_WEIGHT_BASE = 32'h0000_1000;
  localparam logic [31:0] DEFAULT_IM2COL_BASE = 32'h0000_2000;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  // Bits needed to index n entries (at least one bit).
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/skew_line.sv
// Fixed-length delay line for one skewed lane of the feeder output.
// Used only when the FEEDER_SKEW_EN build option is enabled; DEPTH >= 1.
module skew_line #(
  parameter int unsigned DEPTH      = 1,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] dout
);

  logic [DATA_WIDTH-1:0] stage [DEPTH];

  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    if (i == 0) begin : g_head
      // first register samples the undelayed lane
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) stage[i] <= '0;
        else        stage[i] <= din;
      end
    end else begin : g_tail
      // each later register shifts the previous stage by one cycle
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) stage[i] <= '0;
        else        stage[i] <= stage[i-1];
      end
    end
  end

  assign dout = stage[DEPTH-1];

endmodule

// File: rtl/systolic_feeder.sv
// Systolic array feeder: loads an N x K weight matrix and an N x M im2col
// matrix from word-addressed memory into row buffers, then streams one row
// of each per cycle on X/W with valid. Build option FEEDER_SKEW_EN delays
// lane j by j cycles and lengthens the stream to drain the skew.
module systolic_feeder
  import systolic_pkg::*;
#(
  parameter int unsigned           M           = 1,
  parameter int unsigned           N           = 27,
  parameter int unsigned           K           = 2,
  parameter int unsigned           DATA_WIDTH  = 32,
  parameter int unsigned           ADDR_WIDTH  = 32,
  parameter logic [ADDR_WIDTH-1:0] WEIGHT_BASE = ADDR_WIDTH'(DEFAULT_WEIGHT_BASE),
  parameter logic [ADDR_WIDTH-1:0] IM2COL_BASE = ADDR_WIDTH'(DEFAULT_IM2COL_BASE)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  output logic [ADDR_WIDTH-1:0]   addr_rd,
  input  logic [DATA_WIDTH-1:0]   data_rd,
  output logic [DATA_WIDTH*M-1:0] X,
  output logic [DATA_WIDTH*K-1:0] W,
  output logic                    valid,
  output logic                    busy,
  output logic                    done
);

  localparam int unsigned NK = N * K;
  localparam int unsigned NW = N * (K + M);
`ifdef FEEDER_SKEW_EN
  localparam int unsigned SLEN = N + max_u(M, K) - 1;
`else
  localparam int unsigned SLEN = N;
`endif
  localparam int unsigned RW = idx_width(N);
  localparam int unsigned KW = idx_width(K);
  localparam int unsigned MW = idx_width(M);
  localparam int unsigned LW = idx_width(max_u(M, K));
  localparam int unsigned CW = idx_width(NW + 1);
  localparam int unsigned TW = idx_width(SLEN + 1);

  state_t                       state;
  logic [CW-1:0]                ld_cnt;
  logic [RW-1:0]                cap_row;
  logic [LW-1:0]                cap_lane;
  logic                         cap_x;
  logic [LW-1:0]                last_lane;
  logic                         cap_en;
  logic [TW-1:0]                t_cnt;
  logic [TW-1:0]                sel;
  logic [M-1:0][DATA_WIDTH-1:0] x_raw, x_row;
  logic [K-1:0][DATA_WIDTH-1:0] w_raw, w_row;
  logic [K-1:0][DATA_WIDTH-1:0] wbuf [N];
  logic [M-1:0][DATA_WIDTH-1:0] xbuf [N];

  // capture happens one cycle behind each issued address
  always_comb begin
    cap_en    = (state == LOAD) && (ld_cnt != '0);
    last_lane = cap_x ? LW'(M - 1) : LW'(K - 1);
  end

  // row buffers take data_rd at the current capture position
  always_ff @(posedge clk) begin
    if (cap_en) begin
      if (cap_x) xbuf[cap_row][MW'(cap_lane)] <= data_rd;
      else       wbuf[cap_row][KW'(cap_lane)] <= data_rd;
    end
  end

  // select the row to present next; rows past N read as zero (skew drain)
  always_comb begin
    sel   = (state == STREAM) ? t_cnt : '0;
    w_row = '0;
    x_row = '0;
    if (sel < TW'(N)) begin
      w_row = wbuf[RW'(sel)];
      x_row = xbuf[RW'(sel)];
      // the final im2col word lands on the same edge that loads row 0 when
      // N is 1, so forward it straight from the read port
      if (cap_en && cap_x && (cap_row == RW'(sel)))
        x_row[MW'(cap_lane)] = data_rd;
    end
  end

  // controller: address issue, capture bookkeeping and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      addr_rd  <= '0;
      ld_cnt   <= '0;
      cap_row  <= '0;
      cap_lane <= '0;
      cap_x    <= 1'b0;
      t_cnt    <= '0;
      x_raw    <= '0;
      w_raw    <= '0;
      valid    <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state    <= LOAD;
            busy     <= 1'b1;
            addr_rd  <= WEIGHT_BASE;
            ld_cnt   <= '0;
            cap_row  <= '0;
            cap_lane <= '0;
            cap_x    <= 1'b0;
          end
        end
        LOAD: begin
          if (ld_cnt < CW'(NW - 1)) begin
            if (ld_cnt == CW'(NK - 1)) addr_rd <= IM2COL_BASE;
            else                       addr_rd <= addr_rd + ADDR_WIDTH'(1);
          end
          if (cap_en) begin
            if (cap_lane == last_lane) begin
              cap_lane <= '0;
              if (cap_row == RW'(N - 1)) begin
                cap_row <= '0;
                cap_x   <= 1'b1;
              end else begin
                cap_row <= cap_row + RW'(1);
              end
            end else begin
              cap_lane <= cap_lane + LW'(1);
            end
          end
          if (ld_cnt == CW'(NW)) begin
            state <= STREAM;
            x_raw <= x_row;
            w_raw <= w_row;
            valid <= 1'b1;
            t_cnt <= TW'(1);
          end else begin
            ld_cnt <= ld_cnt + CW'(1);
          end
        end
        STREAM: begin
          if (t_cnt == TW'(SLEN)) begin
            state <= DONE;
            valid <= 1'b0;
            x_raw <= '0;
            w_raw <= '0;
            done  <= 1'b1;
          end else begin
            x_raw <= x_row;
            w_raw <= w_row;
            t_cnt <= t_cnt + TW'(1);
          end
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef FEEDER_SKEW_EN
  logic [M-1:0][DATA_WIDTH-1:0] x_dly;
  logic [K-1:0][DATA_WIDTH-1:0] w_dly;

  for (genvar j = 0; j < M; j++) begin : g_x_skew
    if (j == 0) begin : g_direct
      assign x_dly[j] = x_raw[j];
    end else begin : g_line
      skew_line #(.DEPTH(j), .DATA_WIDTH(DATA_WIDTH)) u_line (
        .clk(clk), .rst_n(rst_n), .din(x_raw[j]), .dout(x_dly[j])
      );
    end
  end

  for (genvar j = 0; j < K; j++) begin : g_w_skew
    if (j == 0) begin : g_direct
      assign w_dly[j] = w_raw[j];
    end else begin : g_line
      skew_line #(.DEPTH(j), .DATA_WIDTH(DATA_WIDTH)) u_line (
        .clk(clk), .rst_n(rst_n), .din(w_raw[j]), .dout(w_dly[j])
      );
    end
  end

  assign X = valid ? x_dly : '0;
  assign W = valid ? w_dly : '0;
`else
  assign X = x_raw;
  assign W = w_raw;
`endif

endmodule
